bcd_rtc_clock: RTL and testbench

//  Parametrised BCD real-time clock, the successor to the fixed 12-hour timer.
//  - Adds a seconds prescaler, a runtime 12/24-hour display mode, a validated time load and a second-advance pulse.
//  - Optional minute alarm.
//  - Feeds display drivers and system timestamping from one free-running clock.

---
 rtl/bcd_rtc_pkg.sv | 48 ++++
 rtl/bcd_mod_counter.sv | 28 ++
 rtl/bcd_rtc_clock.sv | 123 ++++++++++++
 tb/tb_bcd_rtc_clock.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_rtc_pkg.sv
// Shared constants and BCD helpers for the BCD real-time clock.
package bcd_rtc_pkg;

    localparam logic [7:0] BCD_MAX_SEC = 8'h59;
    localparam logic [7:0] BCD_MAX_MIN = 8'h59;
    localparam logic [7:0] BCD_MAX_H24 = 8'h23;
    localparam logic [7:0] BCD_NOON    = 8'h12;

    // Both digits legal and value no greater than max (BCD order matches binary order).
    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 12-hour (01-12 plus PM flag) to 24-hour BCD; caller guarantees a valid hour.
    function automatic logic [7:0] h12_to_h24(input logic [7:0] h12, input logic pm);
        if (h12 == BCD_NOON)
            return pm ? BCD_NOON : 8'h00;
        else if (!pm)
            return h12;
        else if (h12[3:0] + 4'd2 > 4'd9)
            return {h12[7:4] + 4'd2, h12[3:0] - 4'd8};
        else
            return {h12[7:4] + 4'd1, h12[3:0] + 4'd2};
    endfunction

    // 24-hour BCD to the 12-hour display digits (00 shows as 12).
    function automatic logic [7:0] h24_to_h12(input logic [7:0] h24);
        if (h24 == 8'h00)
            return BCD_NOON;
        else if (h24 <= BCD_NOON)
            return h24;
        else if (h24[3:0] < 4'd2)
            return {h24[7:4] - 4'd2, h24[3:0] + 4'd8};
        else
            return {h24[7:4] - 4'd1, h24[3:0] - 4'd2};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX; carry_out flags the wrap.
module bcd_mod_counter
    import bcd_rtc_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry_out
);

    assign carry_out = inc && (value == MAX);

    // Load wins over increment; reset wins over both.
    always_ff @(posedge clk) begin
        if (!reset_n)
            value <= 8'h00;
        else if (load)
            value <= load_val;
        else if (inc)
            value <= bcd_inc(value, MAX);
    end

endmodule

// File: rtl/bcd_rtc_clock.sv
// BCD real-time clock with seconds prescaler, runtime 12/24-hour display and
// validated time load. Optional minute alarm enabled by defining BCD_RTC_ALARM_EN.
module bcd_rtc_clock
    import bcd_rtc_pkg::*;
#(
    parameter int CLK_DIV     = 1,
    parameter int DEFAULT_24H = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ena,
    input  logic       mode_24h,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
`ifdef BCD_RTC_ALARM_EN
    input  logic       alarm_en,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic       alarm_hit,
`endif
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       tick,
    output logic       load_err
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    if (CLK_DIV < 1 || DEFAULT_24H < 0 || DEFAULT_24H > 1) begin : g_bad_param
        $error("bcd_rtc_clock: CLK_DIV must be >= 1 and DEFAULT_24H 0 or 1");
    end

    logic [PW-1:0] pcnt;
    logic [7:0]    s_val, m_val, h_val;
    logic          s_carry, m_carry, h_carry;
    logic          hh_ok, load_valid, load_ok, advance, s_inc;
    logic [7:0]    load_h24;

    // Hour range depends on the display format the loader is using.
    assign hh_ok      = mode_24h ? bcd_valid(load_hh, BCD_MAX_H24)
                                 : (bcd_valid(load_hh, BCD_NOON) && (load_hh != 8'h00));
    assign load_valid = hh_ok && bcd_valid(load_mm, BCD_MAX_MIN) && bcd_valid(load_ss, BCD_MAX_SEC);
    assign load_h24   = mode_24h ? load_hh : h12_to_h24(load_hh, load_pm);
    assign load_ok    = load && load_valid;

    // A valid load suppresses the advance entirely; an invalid one does not.
    assign advance = ena && (pcnt == LAST);
    assign s_inc   = advance && !load_ok;

    // Prescaler: frozen by ena=0, restarted by a valid load.
    always_ff @(posedge clk) begin
        if (!reset_n)
            pcnt <= '0;
        else if (load_ok)
            pcnt <= '0;
        else if (ena)
            pcnt <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
    end

    bcd_mod_counter #(.MAX(BCD_MAX_SEC)) u_sec (
        .clk(clk), .reset_n(reset_n), .inc(s_inc), .load(load_ok),
        .load_val(load_ss), .value(s_val), .carry_out(s_carry)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_MIN)) u_min (
        .clk(clk), .reset_n(reset_n), .inc(s_carry), .load(load_ok),
        .load_val(load_mm), .value(m_val), .carry_out(m_carry)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_H24)) u_hour (
        .clk(clk), .reset_n(reset_n), .inc(m_carry), .load(load_ok),
        .load_val(load_h24), .value(h_val), .carry_out(h_carry)
    );

    assign hh = mode_24h ? h_val : h24_to_h12(h_val);
    assign mm = m_val;
    assign ss = s_val;
    assign pm = (h_val >= BCD_NOON);

    // Status pulses line up with the cycle the new state is first visible.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= s_inc;
            load_err <= load && !load_valid;
        end
    end

`ifdef BCD_RTC_ALARM_EN
    logic       alarm_match;
    logic [7:0] m_next, h_next;

    // Time the chain will show after this edge's minute rollover.
    assign m_next      = bcd_inc(m_val, BCD_MAX_MIN);
    assign h_next      = m_carry ? bcd_inc(h_val, BCD_MAX_H24) : h_val;
    assign alarm_match = s_carry && alarm_en && (m_next == alarm_mm) && (h_next == alarm_hh);

    // Fires only on a counted advance onto hh:mm:00, never on a load.
    always_ff @(posedge clk) begin
        if (!reset_n)
            alarm_hit <= 1'b0;
        else
            alarm_hit <= alarm_match;
    end
`else
    logic unused_carry;
    assign unused_carry = h_carry;
`endif

`ifdef BCD_RTC_ALARM_EN
    logic unused_carry_alarm;
    assign unused_carry_alarm = h_carry;
`endif

endmodule

// File: tb/tb_bcd_rtc_clock.sv
// Directed self-checking bench for bcd_rtc_clock (CLK_DIV=4).
module tb_bcd_rtc_clock;

    logic       clk = 1'b0;
    logic       reset_n, ena, mode_24h, load, load_pm;
    logic [7:0] load_hh, load_mm, load_ss;
    logic [7:0] hh, mm, ss;
    logic       pm, tick, load_err;
`ifdef BCD_RTC_ALARM_EN
    logic       alarm_en, alarm_hit;
    logic [7:0] alarm_hh, alarm_mm;
`endif

    int checks   = 0;
    int failures = 0;

    bcd_rtc_clock #(.CLK_DIV(4), .DEFAULT_24H(0)) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .mode_24h(mode_24h),
        .load(load), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .load_pm(load_pm),
`ifdef BCD_RTC_ALARM_EN
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .alarm_hit(alarm_hit),
`endif
        .hh(hh), .mm(mm), .ss(ss), .pm(pm), .tick(tick), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       m24;
        logic       bad;
        logic [7:0] lh, lm, ls;
        logic       lp;
        logic [7:0] eh, em, es;
        logic       ep;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
        load_hh = h; load_mm = m; load_ss = s; load_pm = p; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_tick(input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = tick;
        end
        chk({nm, "_tick_seen"}, {7'd0, got}, 8'h01);
    endtask

    task automatic chk_time(input string nm, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input logic p);
        chk({nm, "_hh"}, hh, h);
        chk({nm, "_mm"}, mm, m);
        chk({nm, "_ss"}, ss, s);
        chk({nm, "_pm"}, {7'd0, pm}, {7'd0, p});
    endtask

    initial begin
        vecs[0]  = '{"am_to_pm",   1'b0, 1'b0, 8'h11, 8'h59, 8'h59, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1};
        vecs[1]  = '{"noon_to_1",  1'b0, 1'b0, 8'h12, 8'h59, 8'h59, 1'b1, 8'h01, 8'h00, 8'h00, 1'b1};
        vecs[2]  = '{"pm_to_mid",  1'b0, 1'b0, 8'h11, 8'h59, 8'h59, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{"h24_wrap",   1'b1, 1'b0, 8'h23, 8'h59, 8'h59, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{"digit_9_10", 1'b0, 1'b0, 8'h09, 8'h59, 8'h59, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{"h24_19_20",  1'b1, 1'b0, 8'h19, 8'h59, 8'h59, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{"bad_h12_13", 1'b0, 1'b1, 8'h13, 8'h00, 8'h00, 1'b0, 8'h05, 8'h06, 8'h07, 1'b0};
        vecs[7]  = '{"bad_mm_60",  1'b0, 1'b1, 8'h10, 8'h60, 8'h00, 1'b0, 8'h05, 8'h06, 8'h07, 1'b0};
        vecs[8]  = '{"bad_ss_0a",  1'b0, 1'b1, 8'h10, 8'h00, 8'h0A, 1'b0, 8'h05, 8'h06, 8'h07, 1'b0};
        vecs[9]  = '{"bad_h24_24", 1'b1, 1'b1, 8'h24, 8'h00, 8'h00, 1'b0, 8'h05, 8'h06, 8'h07, 1'b0};
        vecs[10] = '{"bad_h12_00", 1'b0, 1'b1, 8'h00, 8'h30, 8'h30, 1'b0, 8'h05, 8'h06, 8'h07, 1'b0};

        reset_n = 1'b0; ena = 1'b1; mode_24h = 1'b0; load = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00; load_pm = 1'b0;
`ifdef BCD_RTC_ALARM_EN
        alarm_en = 1'b0; alarm_hh = 8'h00; alarm_mm = 8'h00;
`endif

        // Reset state in both display modes.
        step(); step();
        chk_time("rst12", 8'h12, 8'h00, 8'h00, 1'b0);
        chk("rst_tick", {7'd0, tick}, 8'h00);
        chk("rst_err", {7'd0, load_err}, 8'h00);
        mode_24h = 1'b1; #1;
        chk("rst24_hh", hh, 8'h00);
        mode_24h = 1'b0;

        // Tick every 4th cycle after reset release.
        reset_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            chk($sformatf("period_tick%0d", n), {7'd0, tick}, (n % 4 == 0) ? 8'h01 : 8'h00);
        end
        chk("period_ss", ss, 8'h03);

        // Freeze with ena low mid-second, then resume from the frozen phase.
        step(); step();
        ena = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("frozen_tick", {7'd0, tick}, 8'h00);
        end
        chk("frozen_ss", ss, 8'h03);
        ena = 1'b1;
        step();
        chk("resume_tick1", {7'd0, tick}, 8'h00);
        step();
        chk("resume_tick2", {7'd0, tick}, 8'h01);
        chk("resume_ss", ss, 8'h04);

        // Table: rollovers after valid loads, and rejected loads.
        foreach (vecs[i]) begin
            mode_24h = vecs[i].m24;
            if (!vecs[i].bad) begin
                do_load(vecs[i].lh, vecs[i].lm, vecs[i].ls, vecs[i].lp);
                chk({vecs[i].name, "_noerr"}, {7'd0, load_err}, 8'h00);
                chk({vecs[i].name, "_notick"}, {7'd0, tick}, 8'h00);
                wait_tick(vecs[i].name);
            end else begin
                do_load(8'h05, 8'h06, 8'h07, 1'b0);
                do_load(vecs[i].lh, vecs[i].lm, vecs[i].ls, vecs[i].lp);
                chk({vecs[i].name, "_err"}, {7'd0, load_err}, 8'h01);
                step();
                chk({vecs[i].name, "_err_pulse"}, {7'd0, load_err}, 8'h00);
            end
            chk_time(vecs[i].name, vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ep);
        end

        // Mode toggle at 13:05:00 reformats only.
        mode_24h = 1'b1;
        do_load(8'h13, 8'h05, 8'h00, 1'b0);
        chk_time("tog24", 8'h13, 8'h05, 8'h00, 1'b1);
        mode_24h = 1'b0; #1;
        chk_time("tog12", 8'h01, 8'h05, 8'h00, 1'b1);
        step();
        chk("tog_tick", {7'd0, tick}, 8'h00);
        chk("tog_ss", ss, 8'h00);

        // Load landing on the advance edge wins and suppresses tick.
        do_load(8'h03, 8'h00, 8'h00, 1'b0);
        step(); step(); step();
        do_load(8'h08, 8'h15, 8'h30, 1'b0);
        chk_time("coinc", 8'h08, 8'h15, 8'h30, 1'b0);
        chk("coinc_tick", {7'd0, tick}, 8'h00);
        step(); step(); step();
        chk("coinc_phase3", {7'd0, tick}, 8'h00);
        step();
        chk("coinc_phase4", {7'd0, tick}, 8'h01);
        chk("coinc_ss", ss, 8'h31);

        // Reset mid-second overrides everything.
        step();
        reset_n = 1'b0; load = 1'b1; load_hh = 8'h09;
        step();
        reset_n = 1'b1; load = 1'b0;
        chk_time("midrst", 8'h12, 8'h00, 8'h00, 1'b0);
        step(); step(); step();
        chk("midrst_tick3", {7'd0, tick}, 8'h00);
        step();
        chk("midrst_tick4", {7'd0, tick}, 8'h01);

`ifdef BCD_RTC_ALARM_EN
        mode_24h = 1'b1;
        alarm_en = 1'b1; alarm_hh = 8'h07; alarm_mm = 8'h30;
        do_load(8'h07, 8'h29, 8'h59, 1'b0);
        chk("alarm_idle", {7'd0, alarm_hit}, 8'h00);
        wait_tick("alarm");
        chk("alarm_hit", {7'd0, alarm_hit}, 8'h01);
        chk_time("alarm_time", 8'h07, 8'h30, 8'h00, 1'b0);
        step();
        chk("alarm_pulse", {7'd0, alarm_hit}, 8'h00);
        do_load(8'h07, 8'h30, 8'h00, 1'b0);
        chk("alarm_load", {7'd0, alarm_hit}, 8'h00);
        wait_tick("alarm_after");
        chk("alarm_after", {7'd0, alarm_hit}, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
